// File: rtl/eco32_core_lsu_dcm_rfc_if.sv
// Refill controller bus bundle: LSU packet FIFO head, D-cache data/tag write
// ports, and the thread wake strobe.
interface eco32_core_lsu_dcm_rfc_if #(
    parameter int WORDS   = 4,
    parameter int INDEX_W = 7,
    parameter int TAG_W   = 20
);
    localparam int AW = INDEX_W + $clog2(WORDS);

    logic               rx_hdr_stb;
    logic               rx_hdr_ack;
    logic               rx_data_stb;
    logic               rx_data_flush;
    logic [71:0]        rx_data;
    logic [3:0]         rx_iid;
    logic               port_busy;
    logic               mem_wr_stb;
    logic [AW-1:0]      mem_wr_addr;
    logic [71:0]        mem_wr_data;
    logic               tag_wr_stb;
    logic [INDEX_W-1:0] tag_wr_idx;
    logic [TAG_W-1:0]   tag_wr_tag;
    logic               tag_wr_vld;
    logic               wake_stb;
    logic [3:0]         wake_iid;
    logic               wake_err;
    logic               busy;

    modport master (
        input  rx_hdr_stb, rx_data_stb, rx_data, rx_iid, port_busy,
        output rx_hdr_ack, rx_data_flush, mem_wr_stb, mem_wr_addr, mem_wr_data,
               tag_wr_stb, tag_wr_idx, tag_wr_tag, tag_wr_vld,
               wake_stb, wake_iid, wake_err, busy
    );

    modport slave (
        output rx_hdr_stb, rx_data_stb, rx_data, rx_iid, port_busy,
        input  rx_hdr_ack, rx_data_flush, mem_wr_stb, mem_wr_addr, mem_wr_data,
               tag_wr_stb, tag_wr_idx, tag_wr_tag, tag_wr_vld,
               wake_stb, wake_iid, wake_err, busy
    );
endinterface

// File: rtl/eco32_core_lsu_dcm_rfc.sv
// D-cache refill controller: moves one reply packet (header + WORDS data words)
// into the D-cache data/tag arrays, then wakes the requesting thread.
//
// state | meaning
// IDLE  | waiting for a header; drains stray data words
// DATA  | writing data words into the data array
// TAG   | waiting for the tag port to write a valid tag
// ABORT | data timed out; invalidate the line when the tag port frees up
// WAKE  | pulse wake for the latched thread
module eco32_core_lsu_dcm_rfc #(
    parameter bit FORCE_RST = 1'b1,
    parameter int WORDS     = 4,
    parameter int INDEX_W   = 7,
    parameter int TAG_W     = 20,
    parameter int TIMEOUT   = 255
) (
    input logic clk,
    input logic rst,
    eco32_core_lsu_dcm_rfc_if.master bus
);
    localparam int WW  = $clog2(WORDS);
    localparam int OFS = WW + 3;
    localparam int AW  = INDEX_W + WW;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DATA  = 3'd1;
    localparam logic [2:0] S_TAG   = 3'd2;
    localparam logic [2:0] S_WAKE  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    localparam logic [7:0]    TO_LIM = 8'(TIMEOUT);
    localparam logic [WW-1:0] W_LAST = WW'(WORDS - 1);

    typedef struct packed {
        logic [INDEX_W-1:0] idx;
        logic [TAG_W-1:0]   tag;
        logic [3:0]         iid;
        logic [AW-1:0]      mem_addr;
        logic [71:0]        mem_data;
        logic [INDEX_W-1:0] tag_idx;
        logic [TAG_W-1:0]   tag_tag;
        logic               tag_vld;
        logic [3:0]         wake_iid;
        logic               wake_err;
    } dp_t;

    logic [2:0]    state;
    logic [WW-1:0] wcnt;
    logic [7:0]    tcnt;
    logic          err;
    logic          mem_stb_q, tag_stb_q, wake_stb_q;
    logic          hdr_ack, flush, take_word, tag_go;
    dp_t           dp_q, dp_d;

    // Header wins over a stray data word when both sit at the FIFO head in IDLE.
    always_comb begin
        hdr_ack = 1'b0;
        flush   = 1'b0;
        if (state == S_IDLE) begin
            hdr_ack = bus.rx_hdr_stb;
            flush   = bus.rx_data_stb & ~bus.rx_hdr_stb;
        end else if (state == S_DATA) begin
            flush   = bus.rx_data_stb & ~bus.port_busy;
        end
    end

    assign take_word = (state == S_DATA) & flush;
    assign tag_go    = ((state == S_TAG) | (state == S_ABORT)) & ~bus.port_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wcnt       <= '0;
            tcnt       <= '0;
            err        <= 1'b0;
            mem_stb_q  <= 1'b0;
            tag_stb_q  <= 1'b0;
            wake_stb_q <= 1'b0;
        end else begin
            mem_stb_q  <= take_word;
            tag_stb_q  <= tag_go;
            wake_stb_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hdr_ack) begin
                        wcnt  <= '0;
                        tcnt  <= '0;
                        err   <= 1'b0;
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (take_word) begin
                        tcnt <= '0;
                        if (wcnt == W_LAST) state <= S_TAG;
                        else                wcnt  <= wcnt + WW'(1);
                    end else if (!bus.rx_data_stb) begin
                        if (tcnt != 8'hFF) tcnt <= tcnt + 8'd1;
                        if (tcnt >= TO_LIM - 8'd1) state <= S_ABORT;
                    end
                end
                S_TAG: begin
                    if (tag_go) state <= S_WAKE;
                end
                S_ABORT: begin
                    if (tag_go) begin
                        err   <= 1'b1;
                        state <= S_WAKE;
                    end
                end
                S_WAKE: begin
                    wake_stb_q <= 1'b1;
                    err        <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        dp_d = dp_q;
        if (hdr_ack) begin
            dp_d.idx = bus.rx_data[OFS+INDEX_W-1:OFS];
            dp_d.tag = bus.rx_data[OFS+INDEX_W+TAG_W-1:OFS+INDEX_W];
            dp_d.iid = bus.rx_iid;
        end
        if (take_word) begin
            dp_d.mem_addr = {dp_q.idx, wcnt};
            dp_d.mem_data = bus.rx_data;
        end
        // An aborted refill writes its tag invalid so the partial line never hits.
        if (tag_go) begin
            dp_d.tag_idx = dp_q.idx;
            dp_d.tag_tag = dp_q.tag;
            dp_d.tag_vld = (state == S_TAG);
        end
        if (state == S_WAKE) begin
            dp_d.wake_iid = dp_q.iid;
            dp_d.wake_err = err;
        end
    end

    if (FORCE_RST) begin : g_dp_rst
        always_ff @(posedge clk or posedge rst) begin
            if (rst) dp_q <= '0;
            else     dp_q <= dp_d;
        end
    end else begin : g_dp_nrst
        always_ff @(posedge clk) dp_q <= dp_d;
    end

    assign bus.rx_hdr_ack    = hdr_ack;
    assign bus.rx_data_flush = flush;
    assign bus.mem_wr_stb    = mem_stb_q;
    assign bus.mem_wr_addr   = dp_q.mem_addr;
    assign bus.mem_wr_data   = dp_q.mem_data;
    assign bus.tag_wr_stb    = tag_stb_q;
    assign bus.tag_wr_idx    = dp_q.tag_idx;
    assign bus.tag_wr_tag    = dp_q.tag_tag;
    assign bus.tag_wr_vld    = dp_q.tag_vld;
    assign bus.wake_stb      = wake_stb_q;
    assign bus.wake_iid      = dp_q.wake_iid;
    assign bus.wake_err      = dp_q.wake_err;
    assign bus.busy          = (state != S_IDLE);
endmodule

// File: tb/tb_eco32_core_lsu_dcm_rfc.sv
// Bench for the D-cache refill controller: a FIFO model feeds packets and a
// packet-level model predicts the ordered stream of data/tag/wake writes.
module tb_eco32_core_lsu_dcm_rfc;
    localparam int WORDS   = 4;
    localparam int INDEX_W = 7;
    localparam int TAG_W   = 20;
    localparam int TIMEOUT = 255;
    localparam int WW      = $clog2(WORDS);
    localparam int OFS     = WW + 3;
    localparam int AW      = INDEX_W + WW;
    localparam int PW      = AW + 72;

    typedef logic [PW+1:0] ev_t;
    typedef struct { bit hdr; logic [71:0] data; logic [3:0] iid; } fifo_ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    eco32_core_lsu_dcm_rfc_if #(.WORDS(WORDS), .INDEX_W(INDEX_W), .TAG_W(TAG_W)) bus ();

    eco32_core_lsu_dcm_rfc #(
        .FORCE_RST(1'b1), .WORDS(WORDS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    fifo_ent_t fifo[$];
    ev_t       exp_ev[$], obs_ev[$];
    int        mem_cyc[$], tag_cyc[$], wake_cyc[$], ack_cyc[$], flush_cyc[$];
    int        cyc = 0, n_chk = 0, n_pass = 0;
    int        pb_pct = 0, gap_pct = 0, pb_from = -1, pb_to = -1;

    function automatic ev_t mk_mem(input int unsigned a, input logic [71:0] d);
        return {2'd1, AW'(a), d};
    endfunction

    function automatic ev_t mk_tag(input int unsigned idx, input int unsigned tag, input bit vld);
        return {2'd2, PW'({INDEX_W'(idx), TAG_W'(tag), vld})};
    endfunction

    function automatic ev_t mk_wake(input logic [3:0] iid, input bit err);
        return {2'd3, PW'({iid, err})};
    endfunction

    // Packet-level model: a line of WORDS*8 bytes, index and tag taken from the address.
    task automatic queue_pkt(input logic [31:0] addr, input logic [3:0] iid, input int nw);
        int unsigned idx, tag;
        logic [71:0] w;
        idx = (addr >> OFS) % (1 << INDEX_W);
        tag = (addr >> (OFS + INDEX_W)) % (1 << TAG_W);
        fifo.push_back('{hdr: 1'b1, data: {8'($urandom()), $urandom(), addr}, iid: iid});
        for (int i = 0; i < nw; i++) begin
            w = {8'($urandom()), $urandom(), $urandom()};
            fifo.push_back('{hdr: 1'b0, data: w, iid: iid});
            exp_ev.push_back(mk_mem(idx * WORDS + i, w));
        end
        exp_ev.push_back(mk_tag(idx, tag, nw == WORDS));
        exp_ev.push_back(mk_wake(iid, nw != WORDS));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.rx_hdr_stb  = 1'b0;
        bus.rx_data_stb = 1'b0;
        bus.rx_data     = '0;
        bus.rx_iid      = '0;
        bus.port_busy   = 1'b0;
        fifo.delete();  exp_ev.delete(); obs_ev.delete();
        mem_cyc.delete(); tag_cyc.delete(); wake_cyc.delete();
        ack_cyc.delete(); flush_cyc.delete();
        pb_pct = 0; gap_pct = 0; pb_from = -1; pb_to = -1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock: present the FIFO head, then sample and record DUT activity.
    task automatic step();
        bit avail;
        @(posedge clk);
        #1;
        cyc++;
        avail = (fifo.size() > 0) && ($urandom_range(99) >= gap_pct);
        bus.rx_hdr_stb  = avail && fifo[0].hdr;
        bus.rx_data_stb = avail && !fifo[0].hdr;
        bus.rx_data     = (fifo.size() > 0) ? fifo[0].data : 72'h0;
        bus.rx_iid      = (fifo.size() > 0) ? fifo[0].iid : 4'h0;
        bus.port_busy   = (cyc >= pb_from && cyc < pb_to) || ($urandom_range(99) < pb_pct);
        #3;
        if (bus.mem_wr_stb) begin
            obs_ev.push_back({2'd1, bus.mem_wr_addr, bus.mem_wr_data});
            mem_cyc.push_back(cyc);
        end
        if (bus.tag_wr_stb) begin
            obs_ev.push_back({2'd2, PW'({bus.tag_wr_idx, bus.tag_wr_tag, bus.tag_wr_vld})});
            tag_cyc.push_back(cyc);
        end
        if (bus.wake_stb) begin
            obs_ev.push_back({2'd3, PW'({bus.wake_iid, bus.wake_err})});
            wake_cyc.push_back(cyc);
        end
        if (bus.rx_hdr_ack)    ack_cyc.push_back(cyc);
        if (bus.rx_data_flush) flush_cyc.push_back(cyc);
        if ((bus.rx_hdr_ack || bus.rx_data_flush) && fifo.size() > 0) void'(fifo.pop_front());
    endtask

    task automatic run_until_idle(input int budget, output bit ok);
        int n = 0;
        do begin
            step();
            n++;
        end while ((fifo.size() > 0 || bus.busy) && n < budget);
        ok = (n < budget);
        repeat (3) step();
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #2;
        n_chk++;
        if ({bus.mem_wr_stb, bus.tag_wr_stb, bus.wake_stb, bus.busy} !== 4'b0)
            $display("FAIL reset_held strobes/busy got %b want 0000",
                     {bus.mem_wr_stb, bus.tag_wr_stb, bus.wake_stb, bus.busy});
        else n_pass++;
        rst = 1'b0;
        step();
        n_chk++;
        if ({bus.mem_wr_stb, bus.tag_wr_stb, bus.wake_stb, bus.busy, bus.rx_hdr_ack, bus.rx_data_flush} !== 6'b0)
            $display("FAIL reset_ctrl got %b want 000000",
                     {bus.mem_wr_stb, bus.tag_wr_stb, bus.wake_stb, bus.busy, bus.rx_hdr_ack, bus.rx_data_flush});
        else n_pass++;
        n_chk++;
        if ({bus.mem_wr_addr, bus.mem_wr_data, bus.tag_wr_idx, bus.tag_wr_tag, bus.tag_wr_vld,
             bus.wake_iid, bus.wake_err} !== '0)
            $display("FAIL reset_data got addr %h data %h idx %h tag %h want all 0",
                     bus.mem_wr_addr, bus.mem_wr_data, bus.tag_wr_idx, bus.tag_wr_tag);
        else n_pass++;
    endtask

    task automatic test_basic();
        bit ok;
        int a;
        do_reset();
        queue_pkt(32'h0000_1A40, 4'd3, WORDS);
        run_until_idle(100, ok);
        n_chk++; if (!ok) $display("FAIL basic_budget got timeout want idle"); else n_pass++;
        a = (ack_cyc.size() > 0) ? ack_cyc[0] : 0;
        n_chk++;
        if (ack_cyc.size() != 1) $display("FAIL basic_acks got %0d want 1", ack_cyc.size()); else n_pass++;
        for (int i = 0; i < WORDS; i++) begin
            n_chk++;
            if (i >= mem_cyc.size() || mem_cyc[i] != a + 2 + i)
                $display("FAIL basic_wr_cycle[%0d] got %0d want %0d", i,
                         (i < mem_cyc.size()) ? mem_cyc[i] - a : -1, 2 + i);
            else n_pass++;
        end
        n_chk++;
        if (tag_cyc.size() != 1 || tag_cyc[0] != a + WORDS + 2)
            $display("FAIL basic_tag_cycle got %0d want %0d",
                     (tag_cyc.size() > 0) ? tag_cyc[0] - a : -1, WORDS + 2);
        else n_pass++;
        n_chk++;
        if (wake_cyc.size() != 1 || wake_cyc[0] != a + WORDS + 3)
            $display("FAIL basic_wake_cycle got %0d want %0d",
                     (wake_cyc.size() > 0) ? wake_cyc[0] - a : -1, WORDS + 3);
        else n_pass++;
        n_chk++;
        if (bus.tag_wr_idx !== 7'h52) $display("FAIL basic_idx got %h want 52", bus.tag_wr_idx); else n_pass++;
        n_chk++;
        if (obs_ev.size() != exp_ev.size())
            $display("FAIL basic_events got %0d want %0d", obs_ev.size(), exp_ev.size());
        else n_pass++;
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++;
            if (obs_ev[i] !== exp_ev[i]) $display("FAIL basic_ev[%0d] got %h want %h", i, obs_ev[i], exp_ev[i]);
            else n_pass++;
        end
    endtask

    task automatic test_busy_stall();
        bit ok;
        int a, c0, hits;
        do_reset();
        c0 = cyc;
        pb_from = c0 + 3;
        pb_to   = c0 + 6;
        queue_pkt($urandom(), 4'($urandom_range(15)), WORDS);
        run_until_idle(100, ok);
        n_chk++; if (!ok) $display("FAIL stall_budget got timeout want idle"); else n_pass++;
        a = (ack_cyc.size() > 0) ? ack_cyc[0] : 0;
        n_chk++;
        if (a != c0 + 1) $display("FAIL stall_ack got %0d want %0d", a - c0, 1); else n_pass++;
        hits = 0;
        foreach (flush_cyc[i]) if (flush_cyc[i] >= pb_from && flush_cyc[i] < pb_to) hits++;
        n_chk++;
        if (hits != 0) $display("FAIL stall_flush_while_busy got %0d want 0", hits); else n_pass++;
        n_chk++;
        if (mem_cyc.size() < 2 || mem_cyc[1] != a + 6)
            $display("FAIL stall_word1_cycle got %0d want 6", (mem_cyc.size() > 1) ? mem_cyc[1] - a : -1);
        else n_pass++;
        n_chk++;
        if (wake_cyc.size() != 1 || wake_cyc[0] != a + WORDS + 6)
            $display("FAIL stall_wake_cycle got %0d want %0d",
                     (wake_cyc.size() > 0) ? wake_cyc[0] - a : -1, WORDS + 6);
        else n_pass++;
        n_chk++;
        if (obs_ev.size() != exp_ev.size())
            $display("FAIL stall_events got %0d want %0d", obs_ev.size(), exp_ev.size());
        else n_pass++;
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++;
            if (obs_ev[i] !== exp_ev[i]) $display("FAIL stall_ev[%0d] got %h want %h", i, obs_ev[i], exp_ev[i]);
            else n_pass++;
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int f;
        do_reset();
        queue_pkt($urandom(), 4'($urandom_range(15)), 2);
        run_until_idle(TIMEOUT + 50, ok);
        n_chk++; if (!ok) $display("FAIL timeout_budget got hang want abort"); else n_pass++;
        n_chk++;
        if (flush_cyc.size() != 2) $display("FAIL timeout_flushes got %0d want 2", flush_cyc.size()); else n_pass++;
        f = (flush_cyc.size() > 0) ? flush_cyc[flush_cyc.size() - 1] : 0;
        n_chk++;
        if (tag_cyc.size() != 1 || tag_cyc[0] != f + TIMEOUT + 2)
            $display("FAIL timeout_tag_cycle got %0d want %0d",
                     (tag_cyc.size() > 0) ? tag_cyc[0] - f : -1, TIMEOUT + 2);
        else n_pass++;
        queue_pkt($urandom(), 4'($urandom_range(15)), WORDS);
        run_until_idle(100, ok);
        n_chk++; if (!ok) $display("FAIL timeout_next_budget got timeout want idle"); else n_pass++;
        n_chk++;
        if (obs_ev.size() != exp_ev.size())
            $display("FAIL timeout_events got %0d want %0d", obs_ev.size(), exp_ev.size());
        else n_pass++;
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++;
            if (obs_ev[i] !== exp_ev[i]) $display("FAIL timeout_ev[%0d] got %h want %h", i, obs_ev[i], exp_ev[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        queue_pkt($urandom(), 4'd5, WORDS);
        queue_pkt($urandom(), 4'd9, WORDS);
        run_until_idle(100, ok);
        n_chk++; if (!ok) $display("FAIL b2b_budget got timeout want idle"); else n_pass++;
        n_chk++;
        if (ack_cyc.size() != 2 || wake_cyc.size() != 2)
            $display("FAIL b2b_counts got acks %0d wakes %0d want 2 2", ack_cyc.size(), wake_cyc.size());
        else n_pass++;
        if (ack_cyc.size() == 2 && wake_cyc.size() == 2) begin
            n_chk++;
            if (ack_cyc[1] < wake_cyc[0])
                $display("FAIL b2b_ack_before_wake got ack %0d wake %0d", ack_cyc[1], wake_cyc[0]);
            else n_pass++;
            n_chk++;
            if (ack_cyc[1] - ack_cyc[0] != WORDS + 3)
                $display("FAIL b2b_spacing got %0d want %0d", ack_cyc[1] - ack_cyc[0], WORDS + 3);
            else n_pass++;
        end
        n_chk++;
        if (obs_ev.size() != exp_ev.size())
            $display("FAIL b2b_events got %0d want %0d", obs_ev.size(), exp_ev.size());
        else n_pass++;
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++;
            if (obs_ev[i] !== exp_ev[i]) $display("FAIL b2b_ev[%0d] got %h want %h", i, obs_ev[i], exp_ev[i]);
            else n_pass++;
        end
    endtask

    task automatic test_stray();
        do_reset();
        fifo.push_back('{hdr: 1'b0, data: {8'($urandom()), $urandom(), $urandom()}, iid: 4'h0});
        step();
        n_chk++;
        if (flush_cyc.size() != 1) $display("FAIL stray_flush got %0d want 1", flush_cyc.size()); else n_pass++;
        repeat (3) step();
        n_chk++;
        if (obs_ev.size() != 0 || bus.busy !== 1'b0)
            $display("FAIL stray_side_effects got events %0d busy %b want 0 0", obs_ev.size(), bus.busy);
        else n_pass++;
        @(posedge clk);
        #1;
        bus.rx_hdr_stb  = 1'b1;
        bus.rx_data_stb = 1'b1;
        #3;
        n_chk++;
        if ({bus.rx_hdr_ack, bus.rx_data_flush} !== 2'b10)
            $display("FAIL stray_priority got ack/flush %b want 10", {bus.rx_hdr_ack, bus.rx_data_flush});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        queue_pkt($urandom(), 4'($urandom_range(15)), WORDS);
        repeat (3) step();
        @(posedge clk);
        #1 rst = 1'b1;
        #3;
        n_chk++;
        if ({bus.mem_wr_stb, bus.tag_wr_stb, bus.wake_stb, bus.busy} !== 4'b0)
            $display("FAIL midrst_outputs got %b want 0000",
                     {bus.mem_wr_stb, bus.tag_wr_stb, bus.wake_stb, bus.busy});
        else n_pass++;
        fifo.delete(); exp_ev.delete(); obs_ev.delete();
        tag_cyc.delete(); wake_cyc.delete();
        bus.rx_hdr_stb  = 1'b0;
        bus.rx_data_stb = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        queue_pkt($urandom(), 4'($urandom_range(15)), WORDS);
        run_until_idle(100, ok);
        n_chk++; if (!ok) $display("FAIL midrst_budget got timeout want idle"); else n_pass++;
        n_chk++;
        if (obs_ev.size() != exp_ev.size())
            $display("FAIL midrst_events got %0d want %0d", obs_ev.size(), exp_ev.size());
        else n_pass++;
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++;
            if (obs_ev[i] !== exp_ev[i]) $display("FAIL midrst_ev[%0d] got %h want %h", i, obs_ev[i], exp_ev[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        bit ok;
        int nw;
        do_reset();
        pb_pct  = 25;
        gap_pct = 30;
        for (int p = 0; p < 8; p++) begin
            nw = ($urandom_range(3) == 0) ? int'($urandom_range(WORDS - 1)) : WORDS;
            queue_pkt($urandom(), 4'($urandom_range(15)), nw);
        end
        run_until_idle(6000, ok);
        n_chk++; if (!ok) $display("FAIL random_budget got timeout want idle"); else n_pass++;
        n_chk++;
        if (obs_ev.size() != exp_ev.size())
            $display("FAIL random_events got %0d want %0d", obs_ev.size(), exp_ev.size());
        else n_pass++;
        foreach (exp_ev[i]) if (i < obs_ev.size()) begin
            n_chk++;
            if (obs_ev[i] !== exp_ev[i]) $display("FAIL random_ev[%0d] got %h want %h", i, obs_ev[i], exp_ev[i]);
            else n_pass++;
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_busy_stall();
        test_timeout();
        test_back_to_back();
        test_stray();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
